// File: rtl/muxl2.sv
// Layer-2 lane combiner: merges two half-rate byte lanes (00, 11) into one full-rate
// stream on clk_4f, gated by an idle FSM that waits for traffic and drops back after a quiet run.
module muxl2 #(
    parameter int BW         = 8,
    parameter int IDLE_LIMIT = 4
) (
    input  logic          clk_4f,
    input  logic          reset,
    input  logic [BW-1:0] data_00,
    input  logic          valid_00,
    input  logic [BW-1:0] data_11,
    input  logic          valid_11,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          active
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(IDLE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_LIMIT - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    typedef struct packed {
        logic          v;
        logic [BW-1:0] d;
    } lane_t;

    logic                  phase;
    lane_t [NUM_LANES-1:0] lane_in;
    lane_t [NUM_LANES-1:0] cap;
    state_t                state_q, state_d;
    logic [CW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [BW-1:0]         data_d;
    logic                  valid_d;
    logic                  active_d;
    logic                  any_cap;

    assign lane_in[0] = '{v: valid_00, d: data_00};
    assign lane_in[1] = '{v: valid_11, d: data_11};

    // Phase 0 starts a lane period; the first edge after reset is a phase-0 edge.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) phase <= 1'b0;
        else       phase <= ~phase;
    end

    // Capture on the phase-1 edge; the same edge still emits the old lane-11 word.
    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            always_ff @(posedge clk_4f or posedge reset) begin
                if (reset)      cap[g] <= '0;
                else if (phase) cap[g] <= lane_in[g];
            end
        end
    endgenerate

    assign any_cap = cap[0].v | cap[1].v;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // FSM only moves on phase-0 edges, once per captured pair.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        if (!phase) begin
            case (state_q)
                IDLE: begin
                    if (any_cap) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (any_cap) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == CNT_LAST) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end
            endcase
        end
    end

    // Slot select follows phase: lane 00 on phase 0, lane 11 on phase 1.
    always_comb begin
        valid_d  = cap[phase].v && (state_d == ACTIVE);
        data_d   = valid_d ? cap[phase].d : '0;
        active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            data_out  <= data_d;
            valid_out <= valid_d;
            active    <= active_d;
        end
    end

endmodule

// File: tb/tb_muxl2.sv
// Bench for muxl2: drives lane pairs per period and compares every output cycle
// against a pair-level reference model of the interleave and the idle rules.
module tb_muxl2;
    localparam int BW         = 8;
    localparam int IDLE_LIMIT = 4;

    logic          clk_4f = 1'b0;
    logic          reset  = 1'b0;
    logic [BW-1:0] data_00 = '0, data_11 = '0;
    logic          valid_00 = 1'b0, valid_11 = 1'b0;
    logic [BW-1:0] data_out;
    logic          valid_out, active;

    muxl2 #(.BW(BW), .IDLE_LIMIT(IDLE_LIMIT)) dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_00  (data_00),
        .valid_00 (valid_00),
        .data_11  (data_11),
        .valid_11 (valid_11),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic [BW-1:0] w0, w1;
        logic          v0, v1, act;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    int   cur = 0;
    bit   m_active = 0;
    int   m_quiet = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Pair-level model: a pair is shown only if the combiner is active once it is evaluated.
    task automatic model_pair(input bit v0, input logic [BW-1:0] d0,
                              input bit v1, input logic [BW-1:0] d1);
        exp_t e;
        if (v0 || v1) begin
            m_active = 1;
            m_quiet  = 0;
        end else if (m_active) begin
            m_quiet++;
            if (m_quiet == IDLE_LIMIT) begin
                m_active = 0;
                m_quiet  = 0;
            end
        end
        e.act = m_active;
        e.v0  = m_active && v0;
        e.v1  = m_active && v1;
        e.w0  = e.v0 ? d0 : '0;
        e.w1  = e.v1 ? d1 : '0;
        exp_q.push_back(e);
    endtask

    task automatic check_edge(input int k);
        exp_t e;
        if (cur == 0) begin
            chk("lead_data", data_out, 0);
            chk("lead_valid", valid_out, 0);
            chk("lead_active", active, 0);
        end else begin
            e = exp_q[cur-1];
            chk(k == 0 ? "data_00" : "data_11", data_out, k == 0 ? e.w0 : e.w1);
            chk(k == 0 ? "valid_00" : "valid_11", valid_out, k == 0 ? e.v0 : e.v1);
            chk("active", active, e.act);
        end
    endtask

    task automatic do_pair(input bit v0, input logic [BW-1:0] d0,
                           input bit v1, input logic [BW-1:0] d1, input int edges = 2);
        valid_00 = v0; data_00 = d0;
        valid_11 = v1; data_11 = d1;
        model_pair(v0, d0, v1, d1);
        for (int k = 0; k < edges; k++) begin
            @(posedge clk_4f);
            #1;
            check_edge(k);
        end
        if (edges == 2) cur++;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) do_pair(0, 8'($urandom), 0, 8'($urandom));
    endtask

    // Reset lands between clock edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_active", active, 0);
        valid_00 = 0; valid_11 = 0;
        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f);
        reset = 1'b0;
        exp_q.delete();
        cur      = 0;
        m_active = 0;
        m_quiet  = 0;
    endtask

    initial begin
        bit v0, v1;
        do_reset();

        // ordering
        do_pair(1, 8'hff, 1, 8'hdd);
        do_pair(1, 8'hee, 1, 8'hcc);
        do_pair(1, 8'hbb, 1, 8'h99);
        do_pair(1, 8'haa, 1, 8'h88);
        flush(5);

        // masking
        do_pair(0, 8'h55, 1, 8'h77);
        do_pair(1, 8'h12, 0, 8'h34);
        flush(5);

        // idle entry: random data, no valids, 40 cycles
        do_reset();
        flush(20);

        // idle exit then re-entry
        do_pair(1, 8'h01, 1, 8'h02);
        do_pair(1, 8'h03, 0, 8'h04);
        flush(IDLE_LIMIT);
        do_pair(1, 8'h05, 1, 8'h06);
        do_pair(0, 8'h07, 0, 8'h08);
        do_pair(0, 8'h09, 1, 8'h0a);
        flush(IDLE_LIMIT + 1);

        // reset with a half-emitted pair
        do_pair(1, 8'h11, 1, 8'h22);
        do_pair(1, 8'h33, 1, 8'h44);
        do_pair(1, 8'h55, 1, 8'h66, 1);
        do_reset();
        do_pair(1, 8'h77, 1, 8'h88);
        do_pair(1, 8'h99, 1, 8'haa);
        flush(2);

        // randomized traffic with quiet stretches
        for (int i = 0; i < 120; i++) begin
            if ((i / 10) % 3 == 2) begin
                v0 = 0; v1 = 0;
            end else begin
                v0 = ($urandom_range(0, 2) == 0);
                v1 = ($urandom_range(0, 2) == 0);
            end
            do_pair(v0, 8'($urandom), v1, 8'($urandom));
            if (i == 57) do_reset();
        end
        flush(IDLE_LIMIT + 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
